alu_ctrl_pipe: RTL and testbench
================================

// Module: alu_ctrl_pipe
// PURPOSE
//  Next-generation ALU control for the 5-stage MIPS core. Decodes op/funct in the
//  D stage into an ALUOP_W-bit aluop code and registers it into E. The E register
//  supports stall and flush. A sequencer for multi-cycle MULT/MULTU/DIV/DIVU
//  counts their latency and raises a pipeline stall request until the result is ready.
// PARAMETERS
//  ALUOP_W     8   aluop code width; codes are the `ALUOP_* macros in defines.vh, zero-extended
//  DIV_CYCLES  32  E-stage cycles a DIV/DIVU occupies, >=2
//  MUL_CYCLES  2   E-stage cycles a MULT/MULTU occupies, >=2
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        synchronous reset, active-high
//  instrD      in   32       D-stage instruction; op=[31:26], funct=[5:0]
//  stallE      in   1        hold the E register (hazard unit)
//  flushE      in   1        load a bubble into the E register
//  aluopE      out  ALUOP_W  registered aluop for E
//  md_start    out  1        one-cycle pulse: launch HI/LO unit
//  md_is_div   out  1        qualifies md_start: 1=DIV/DIVU, 0=MULT/MULTU
//  stall_md    out  1        stall request to hazard unit while the op is in flight
//  md_ready    out  1        one-cycle pulse: HI/LO result valid
// BEHAVIOUR
//  Decode (combinational, aluopD):
//  - R-type logic, arith, shift and HI/LO-move functs map to matching `ALUOP_*.
//  - MULT/MULTU/DIV/DIVU (funct 0x18/0x19/0x1A/0x1B) map to `ALUOP_MULT/MULTU/DIV/DIVU.
//  - ANDI/XORI/ORI/LUI/ADDI/ADDIU/SLTI/SLTIU map to their own codes.
//  - LB/LBU/LH/LHU/LW/SB/SH/SW map to `ALUOP_ADD.
//  - Branches, jumps and undefined op/funct map to 0.
//  E register (priority rst > flushE > stallE > load):
//  - rst or flushE: aluopE <= 0, e_new <= 0.
//  - stallE: hold aluopE, e_new <= 0.
//  - Otherwise: aluopE <= aluopD, e_new <= 1.
//  - e_new means "E holds an instruction that entered last cycle". A held DIV is never relaunched.
//  Sequencer FSM, states IDLE/BUSY/DONE; counter cnt is clog2(max cycles) bits:
//  - IDLE: if e_new & aluopE is mul/div & !flushE, then md_start=1 and md_is_div is set by
//    type (both combinational), lat latches the latency, cnt<=0, next state BUSY.
//  - BUSY: stall_md=1, cnt increments. When cnt==lat-1, next state DONE.
//  - DONE: md_ready=1 and stall_md=0 for one cycle, then IDLE.
//  - flushE in BUSY/DONE: next state IDLE, cnt<=0, md_ready suppressed in that cycle.
//  - stallE has no effect on the FSM.
//  - Non-mul/div ops never leave IDLE.
//  Reset values: aluopE=0, state=IDLE, cnt=0, md_start=0, md_is_div=0, stall_md=0, md_ready=0.
//  rst mid-operation aborts to IDLE with no md_ready.
//  Timing:
//  - Decode-to-aluopE latency is 1 clock.
//  - A mul/div in E at cycle T sets md_start at T, stall_md at T+1..T+lat, md_ready at T+lat+1.
// TESTING
//  1 instrD=0x00851020 (ADD), no stall -> next cycle aluopE=`ALUOP_ADD; md_start/stall_md stay 0.
//  2 instrD=0x3C011234 (LUI), then 0x8C220004 (LW) -> aluopE=`ALUOP_LUI, then `ALUOP_ADD.
//    Then 0x08000010 (J) -> aluopE=0.
//  3 DIV_CYCLES=4, instrD=0x0085001A (DIV) loaded at T, stallE driven by stall_md ->
//    md_start=1 and md_is_div=1 at T; stall_md=1 at T+1..T+4; md_ready=1 at T+5.
//    Then IDLE, with no relaunch while aluopE still holds DIV.
//  4 MULT 0x00850018 with MUL_CYCLES=2 -> md_start at T, md_is_div=0, stall_md at T+1..T+2,
//    md_ready at T+3.
//  5 DIV in BUSY at cnt=1, pulse flushE -> aluopE=0, IDLE next cycle, md_ready never asserts.
//    Same with rst instead of flushE.
//  6 stallE=1 for 3 cycles with ADDI 0x20420001 in E and SUB in D -> aluopE holds `ALUOP_ADDI.
//    flushE together with stallE -> aluopE=0 next cycle.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// ALU control for the 5-stage MIPS core: D-stage op/funct decode, E-stage aluop
// register with stall/flush, and a latency sequencer for multi-cycle MULT/DIV.

package alu_ctrl_pkg;
    localparam logic [7:0] ALUOP_AND   = 8'h01;
    localparam logic [7:0] ALUOP_OR    = 8'h02;
    localparam logic [7:0] ALUOP_XOR   = 8'h03;
    localparam logic [7:0] ALUOP_NOR   = 8'h04;
    localparam logic [7:0] ALUOP_ADD   = 8'h05;
    localparam logic [7:0] ALUOP_ADDU  = 8'h06;
    localparam logic [7:0] ALUOP_SUB   = 8'h07;
    localparam logic [7:0] ALUOP_SUBU  = 8'h08;
    localparam logic [7:0] ALUOP_SLT   = 8'h09;
    localparam logic [7:0] ALUOP_SLTU  = 8'h0A;
    localparam logic [7:0] ALUOP_SLL   = 8'h0B;
    localparam logic [7:0] ALUOP_SRL   = 8'h0C;
    localparam logic [7:0] ALUOP_SRA   = 8'h0D;
    localparam logic [7:0] ALUOP_SLLV  = 8'h0E;
    localparam logic [7:0] ALUOP_SRLV  = 8'h0F;
    localparam logic [7:0] ALUOP_SRAV  = 8'h10;
    localparam logic [7:0] ALUOP_MFHI  = 8'h11;
    localparam logic [7:0] ALUOP_MFLO  = 8'h12;
    localparam logic [7:0] ALUOP_MTHI  = 8'h13;
    localparam logic [7:0] ALUOP_MTLO  = 8'h14;
    localparam logic [7:0] ALUOP_MULT  = 8'h15;
    localparam logic [7:0] ALUOP_MULTU = 8'h16;
    localparam logic [7:0] ALUOP_DIV   = 8'h17;
    localparam logic [7:0] ALUOP_DIVU  = 8'h18;
    localparam logic [7:0] ALUOP_ANDI  = 8'h19;
    localparam logic [7:0] ALUOP_ORI   = 8'h1A;
    localparam logic [7:0] ALUOP_XORI  = 8'h1B;
    localparam logic [7:0] ALUOP_LUI   = 8'h1C;
    localparam logic [7:0] ALUOP_ADDI  = 8'h1D;
    localparam logic [7:0] ALUOP_ADDIU = 8'h1E;
    localparam logic [7:0] ALUOP_SLTI  = 8'h1F;
    localparam logic [7:0] ALUOP_SLTIU = 8'h20;
endpackage

module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 8,
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instrD,
    input  logic               stallE,
    input  logic               flushE,
    output logic [ALUOP_W-1:0] aluopE,
    output logic               md_start,
    output logic               md_is_div,
    output logic               stall_md,
    output logic               md_ready
);

    localparam int MAXC  = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    // Latency is held as lat-1 so a 32-cycle divide fits the clog2-sized counter.
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [7:0]         code;
    logic [ALUOP_W-1:0] aluopD;
    logic               e_new;
    logic               is_md;
    logic               is_div;
    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CNT_W-1:0]   lat_last, lat_nx;
    logic               unused_fields;

    assign op            = instrD[31:26];
    assign funct         = instrD[5:0];
    assign unused_fields = ^instrD[25:6];

    always_comb begin
        code = '0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00: code = ALUOP_SLL;
                    6'h02: code = ALUOP_SRL;
                    6'h03: code = ALUOP_SRA;
                    6'h04: code = ALUOP_SLLV;
                    6'h06: code = ALUOP_SRLV;
                    6'h07: code = ALUOP_SRAV;
                    6'h10: code = ALUOP_MFHI;
                    6'h11: code = ALUOP_MTHI;
                    6'h12: code = ALUOP_MFLO;
                    6'h13: code = ALUOP_MTLO;
                    6'h18: code = ALUOP_MULT;
                    6'h19: code = ALUOP_MULTU;
                    6'h1A: code = ALUOP_DIV;
                    6'h1B: code = ALUOP_DIVU;
                    6'h20: code = ALUOP_ADD;
                    6'h21: code = ALUOP_ADDU;
                    6'h22: code = ALUOP_SUB;
                    6'h23: code = ALUOP_SUBU;
                    6'h24: code = ALUOP_AND;
                    6'h25: code = ALUOP_OR;
                    6'h26: code = ALUOP_XOR;
                    6'h27: code = ALUOP_NOR;
                    6'h2A: code = ALUOP_SLT;
                    6'h2B: code = ALUOP_SLTU;
                    default: code = '0;
                endcase
            end
            6'h08: code = ALUOP_ADDI;
            6'h09: code = ALUOP_ADDIU;
            6'h0A: code = ALUOP_SLTI;
            6'h0B: code = ALUOP_SLTIU;
            6'h0C: code = ALUOP_ANDI;
            6'h0D: code = ALUOP_ORI;
            6'h0E: code = ALUOP_XORI;
            6'h0F: code = ALUOP_LUI;
            // Loads and stores only need the address add.
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: code = ALUOP_ADD;
            default: code = '0;
        endcase
    end

    assign aluopD = ALUOP_W'(code);

    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            aluopE <= '0;
            e_new  <= 1'b0;
        end else if (stallE) begin
            e_new  <= 1'b0;
        end else begin
            aluopE <= aluopD;
            e_new  <= 1'b1;
        end
    end

    assign is_div = (aluopE == ALUOP_W'(ALUOP_DIV)) || (aluopE == ALUOP_W'(ALUOP_DIVU));
    assign is_md  = is_div || (aluopE == ALUOP_W'(ALUOP_MULT)) ||
                    (aluopE == ALUOP_W'(ALUOP_MULTU));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lat_last <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            lat_last <= lat_nx;
        end
    end

    // Outputs are gated by rst so the reset cycle itself shows idle values.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        lat_nx    = lat_last;
        md_start  = 1'b0;
        md_is_div = 1'b0;
        stall_md  = 1'b0;
        md_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rst && e_new && is_md && !flushE) begin
                    md_start  = 1'b1;
                    md_is_div = is_div;
                    lat_nx    = is_div ? DIV_LAST : MUL_LAST;
                    cnt_nx    = '0;
                    state_nx  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_md = !rst;
                if (flushE) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == lat_last) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                md_ready = !rst && !flushE;
                state_nx = S_IDLE;
                if (flushE) cnt_nx = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: timeline model of decode/E-register/mul-div latency
// checked every cycle, plus directed vectors with literal expectations.

module tb_alu_ctrl_pipe;
    import alu_ctrl_pkg::*;

    localparam int DIVC = 4;
    localparam int MULC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD;
    logic        stall_ext;
    logic        stallE;
    logic        flushE;
    logic [7:0]  aluopE;
    logic        md_start, md_is_div, stall_md, md_ready;

    assign stallE = stall_ext | stall_md;

    alu_ctrl_pipe #(.ALUOP_W(8), .DIV_CYCLES(DIVC), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst(rst), .instrD(instrD), .stallE(stallE), .flushE(flushE),
        .aluopE(aluopE), .md_start(md_start), .md_is_div(md_is_div),
        .stall_md(stall_md), .md_ready(md_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    lit_t        lit_q[$];
    logic [7:0]  fmap[int];
    logic [7:0]  omap[int];
    int unsigned npass = 0;
    int unsigned ntot  = 0;

    initial begin
        fmap[6'h00] = ALUOP_SLL;  fmap[6'h02] = ALUOP_SRL;   fmap[6'h03] = ALUOP_SRA;
        fmap[6'h04] = ALUOP_SLLV; fmap[6'h06] = ALUOP_SRLV;  fmap[6'h07] = ALUOP_SRAV;
        fmap[6'h10] = ALUOP_MFHI; fmap[6'h11] = ALUOP_MTHI;  fmap[6'h12] = ALUOP_MFLO;
        fmap[6'h13] = ALUOP_MTLO; fmap[6'h18] = ALUOP_MULT;  fmap[6'h19] = ALUOP_MULTU;
        fmap[6'h1A] = ALUOP_DIV;  fmap[6'h1B] = ALUOP_DIVU;  fmap[6'h20] = ALUOP_ADD;
        fmap[6'h21] = ALUOP_ADDU; fmap[6'h22] = ALUOP_SUB;   fmap[6'h23] = ALUOP_SUBU;
        fmap[6'h24] = ALUOP_AND;  fmap[6'h25] = ALUOP_OR;    fmap[6'h26] = ALUOP_XOR;
        fmap[6'h27] = ALUOP_NOR;  fmap[6'h2A] = ALUOP_SLT;   fmap[6'h2B] = ALUOP_SLTU;
        omap[6'h08] = ALUOP_ADDI; omap[6'h09] = ALUOP_ADDIU; omap[6'h0A] = ALUOP_SLTI;
        omap[6'h0B] = ALUOP_SLTIU; omap[6'h0C] = ALUOP_ANDI; omap[6'h0D] = ALUOP_ORI;
        omap[6'h0E] = ALUOP_XORI; omap[6'h0F] = ALUOP_LUI;
        omap[6'h20] = ALUOP_ADD;  omap[6'h21] = ALUOP_ADD;   omap[6'h23] = ALUOP_ADD;
        omap[6'h24] = ALUOP_ADD;  omap[6'h25] = ALUOP_ADD;   omap[6'h28] = ALUOP_ADD;
        omap[6'h29] = ALUOP_ADD;  omap[6'h2B] = ALUOP_ADD;
    end

    function automatic logic [7:0] exp_decode(logic [31:0] i);
        int op = int'(i[31:26]);
        int f  = int'(i[5:0]);
        if (op == 0) return fmap.exists(f) ? fmap[f] : 8'h00;
        return omap.exists(op) ? omap[op] : 8'h00;
    endfunction

    function automatic bit m_is_div(logic [7:0] a);
        return (a == ALUOP_DIV) || (a == ALUOP_DIVU);
    endfunction

    function automatic bit m_is_md(logic [7:0] a);
        return m_is_div(a) || (a == ALUOP_MULT) || (a == ALUOP_MULTU);
    endfunction

    // Model state: E contents plus the launch time/latency of the op in flight.
    logic [7:0]  m_aluop = 8'h00;
    bit          m_new   = 1'b0;
    bit          m_act   = 1'b0;
    int unsigned m_t     = 0;
    int unsigned m_lat   = 0;
    int unsigned cyc     = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] sig_val(int s);
        case (s)
            0: return 32'(aluopE);
            1: return 32'(md_start);
            2: return 32'(md_is_div);
            3: return 32'(stall_md);
            default: return 32'(md_ready);
        endcase
    endfunction

    always @(negedge clk) begin
        bit   e_start, e_stall, e_ready;
        lit_t it;
        e_stall = !rst && m_act && (cyc >= m_t + 1) && (cyc <= m_t + m_lat);
        e_ready = !rst && m_act && (cyc == m_t + m_lat + 1) && !flushE;
        e_start = !rst && !m_act && m_new && m_is_md(m_aluop) && !flushE;
        check("aluopE",    32'(aluopE),    32'(m_aluop));
        check("md_start",  32'(md_start),  32'(e_start));
        check("md_is_div", 32'(md_is_div), 32'(e_start && m_is_div(m_aluop)));
        check("stall_md",  32'(stall_md),  32'(e_stall));
        check("md_ready",  32'(md_ready),  32'(e_ready));
        while (lit_q.size() > 0) begin
            it = lit_q.pop_front();
            check(it.name, (it.sig < 0) ? it.act : sig_val(it.sig), it.exp);
        end
        if (rst) begin
            m_aluop = 8'h00;
            m_new   = 1'b0;
            m_act   = 1'b0;
        end else begin
            if (m_act) begin
                if (flushE || cyc == m_t + m_lat + 1) m_act = 1'b0;
            end else if (e_start) begin
                m_act = 1'b1;
                m_t   = cyc;
                m_lat = m_is_div(m_aluop) ? DIVC : MULC;
            end
            if (flushE) begin
                m_aluop = 8'h00;
                m_new   = 1'b0;
            end else if (stallE) begin
                m_new = 1'b0;
            end else begin
                m_aluop = exp_decode(instrD);
                m_new   = 1'b1;
            end
        end
        cyc++;
    end

    task automatic lit(string name, int sig, logic [31:0] exp);
        lit_t it;
        it.name = name; it.sig = sig; it.act = '0; it.exp = exp;
        lit_q.push_back(it);
    endtask

    task automatic lit_val(string name, logic [31:0] act, logic [31:0] exp);
        lit_t it;
        it.name = name; it.sig = -1; it.act = act; it.exp = exp;
        lit_q.push_back(it);
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Steps until md_ready, returning cycles elapsed (0 on timeout) and stall cycles seen.
    task automatic wait_ready(output int unsigned n, output int unsigned stalls);
        n = 0;
        stalls = 0;
        for (int unsigned k = 1; k <= 40; k++) begin
            step();
            if (stall_md) stalls++;
            if (md_ready) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_ready(int unsigned n, output int unsigned r);
        r = 0;
        for (int unsigned k = 0; k < n; k++) begin
            step();
            if (md_ready) r++;
        end
    endtask

    logic [31:0] dins [15] = '{32'h00851020, 32'h3C011234, 32'h8C220004, 32'h08000010,
                               32'h30A5000F, 32'h0085102B, 32'h00021043, 32'h00001010,
                               32'h03E00008, 32'hFC000000, 32'hA0A20000, 32'h34A5FFFF,
                               32'h00851027, 32'h2CA50007, 32'h10850003};
    logic [7:0]  dexp [15] = '{ALUOP_ADD,  ALUOP_LUI,  ALUOP_ADD, 8'h00,
                               ALUOP_ANDI, ALUOP_SLTU, ALUOP_SRA, ALUOP_MFHI,
                               8'h00,      8'h00,      ALUOP_ADD, ALUOP_ORI,
                               ALUOP_NOR,  ALUOP_SLTIU, 8'h00};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, s, r;
        rst = 1'b1; instrD = 32'h0; stall_ext = 1'b0; flushE = 1'b0;
        step(2);
        lit("reset_aluopE", 0, 32'h0);
        lit("reset_stall_md", 3, 32'h0);
        rst = 1'b0;
        instrD = 32'h00000020;
        step();

        for (int i = 0; i < 15; i++) begin
            instrD = dins[i];
            step();
            lit($sformatf("decode_%0d", i), 0, 32'(dexp[i]));
            lit($sformatf("decode_nostart_%0d", i), 1, 32'h0);
        end

        // DIV, with E held on the DIV for the whole operation and afterwards.
        instrD = 32'h0085001A;
        step();
        stall_ext = 1'b1;
        instrD = 32'h00851020;
        lit("div_start", 1, 32'h1);
        lit("div_is_div", 2, 32'h1);
        wait_ready(n, s);
        lit_val("div_ready_latency", n, 32'd5);
        lit_val("div_stall_cycles", s, 32'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            lit("div_no_relaunch", 1, 32'h0);
            lit("div_held", 0, 32'(ALUOP_DIV));
        end
        stall_ext = 1'b0;
        step();

        // A flush arriving with a freshly loaded DIVU blocks the launch.
        instrD = 32'h0085001B;
        step();
        flushE = 1'b1;
        instrD = 32'h00851020;
        lit("flush_blocks_start", 1, 32'h0);
        step();
        flushE = 1'b0;
        lit("flush_bubble", 0, 32'h0);
        step();

        instrD = 32'h00850018;
        step();
        instrD = 32'h00851020;
        lit("mult_start", 1, 32'h1);
        lit("mult_is_div", 2, 32'h0);
        wait_ready(n, s);
        lit_val("mult_ready_latency", n, 32'd3);
        lit_val("mult_stall_cycles", s, 32'd2);
        step(2);

        // Abort a DIV in flight by flush, then by reset.
        instrD = 32'h0085001A;
        step();
        instrD = 32'h00851020;
        step(2);
        flushE = 1'b1;
        lit("abort_busy", 3, 32'h1);
        step();
        flushE = 1'b0;
        lit("abort_flush_aluop", 0, 32'h0);
        lit("abort_flush_idle", 3, 32'h0);
        count_ready(8, r);
        lit_val("abort_flush_no_ready", r, 32'd0);

        instrD = 32'h0085001B;
        step();
        instrD = 32'h00851020;
        step(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        lit("abort_rst_aluop", 0, 32'h0);
        lit("abort_rst_idle", 3, 32'h0);
        count_ready(8, r);
        lit_val("abort_rst_no_ready", r, 32'd0);

        // Stall holds ADDI; flush wins over stall.
        instrD = 32'h20420001;
        step();
        instrD = 32'h00851022;
        stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            lit("stall_hold_addi", 0, 32'(ALUOP_ADDI));
        end
        flushE = 1'b1;
        step();
        flushE = 1'b0;
        stall_ext = 1'b0;
        lit("flush_over_stall", 0, 32'h0);
        step();
        lit("sub_after_release", 0, 32'(ALUOP_SUB));

        step(2);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
